// File: rtl/write_port_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register.
// Optional ARB_LOCK_EN: a granted requester with lock_i=1 keeps priority.
module write_port_arbiter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] data0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [W-1:0] data1,
    output logic         gnt1,
    input  logic         lock0,
    input  logic         lock1,
    output logic         sel,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_src,
    input  logic         out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t       state_q, state_d;
    logic         prio_q, prio_d;
    logic         winner;
    logic         slot_free;
    logic         capture;
    logic         win_lock;

`ifdef ARB_LOCK_EN
    assign win_lock = winner ? lock1 : lock0;
`else
    logic unused_lock;
    assign unused_lock = lock0 | lock1;
    assign win_lock    = 1'b0;
`endif

    // A contested slot goes to prio; otherwise the sole requester wins.
    assign winner    = (req0 & req1) ? prio_q : req1;
    assign slot_free = (state_q == EMPTY) | out_ready;
    // Gated by reset so no grant is issued while the async reset is held.
    assign capture   = slot_free & (req0 | req1) & ~reset;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        sel     = prio_q;
        if (capture) begin
            gnt0    = ~winner;
            gnt1    = winner;
            sel     = winner;
            state_d = FULL;
            prio_d  = win_lock ? winner : ~winner;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            prio_q   <= 1'b0;
            out_data <= '0;
            out_src  <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (capture) begin
                out_data <= sel ? data1 : data0;
                out_src  <= winner;
            end
        end
    end

    assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_write_port_arbiter.sv
// Randomized and directed bench for write_port_arbiter against a
// transaction-level model of the slot, priority and lock rules.
module tb_write_port_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic         lock0 = 1'b0, lock1 = 1'b0;
    logic         out_ready = 1'b0;
    logic         gnt0, gnt1, sel, out_valid, out_src;
    logic [W-1:0] out_data;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Model state: contents of the output slot and who is favoured next.
    bit           m_full = 0;
    logic [W-1:0] m_data = '0;
    int           m_src = 0;
    int           m_prio = 0;
    int           m_last_gnt = -1;

    write_port_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .data1(data1), .gnt1(gnt1),
        .lock0(lock0), .lock1(lock1),
        .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_data = '0; m_src = 0; m_prio = 0; m_last_gnt = -1;
    endtask

    // Drive one cycle, check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle(input bit r0, input logic [W-1:0] d0, input bit r1,
                         input logic [W-1:0] d1, input bit l0, input bit l1, input bit rdy);
        int  win;
        bit  grant;
        bit  keep;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
        lock0 = l0; lock1 = l1; out_ready = rdy;
        @(negedge clk);
        grant = (!m_full || rdy) && (r0 || r1);
        if (r0 && r1) win = m_prio;
        else          win = r1 ? 1 : 0;
        check("out_valid", out_valid, m_full);
        check("out_data", out_data, m_data);
        check("out_src", out_src, m_src);
        check("gnt0", gnt0, grant && win == 0);
        check("gnt1", gnt1, grant && win == 1);
        check("sel", sel, grant ? win : m_prio);
        @(posedge clk);
        m_last_gnt = grant ? win : -1;
        if (grant) begin
            m_data = win ? d1 : d0;
            m_src  = win;
            m_full = 1;
`ifdef ARB_LOCK_EN
            keep = win ? l1 : l0;
`else
            keep = 0;
`endif
            m_prio = keep ? win : 1 - win;
        end else if (rdy) begin
            m_full = 0;
        end
        #1;
    endtask

    initial begin
        bit           p0, p1;
        logic [W-1:0] pd0, pd1;
        bit           l0, l1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_src", out_src, 1'b0);
        check("rst_gnt0", gnt0, 1'b0);
        check("rst_sel", sel, 1'b0);
        reset = 1'b0;
        model_reset();

        // Single requester, first-transfer latency.
        cycle(1, 32'hAAAA5555, 0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 32'h0, 0, 0, 1);

        // Both held: alternation.
        repeat (6) cycle(1, 32'h10, 1, 32'h20, 0, 0, 1);

        // Stall while full, then back-to-back refill.
        cycle(0, 32'h0, 1, 32'h77, 0, 0, 0);
        repeat (3) cycle(0, 32'h0, 1, 32'h77, 0, 0, 0);
        cycle(0, 32'h0, 1, 32'h77, 0, 0, 1);
        cycle(0, 32'h0, 0, 32'h0, 0, 0, 0);

        // Reset while full: immediate clear and no grant while asserted.
        req1 = 1'b1; data1 = 32'h55; out_ready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_gnt1", gnt1, 1'b0);
        check("midrst_data", out_data, '0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        cycle(0, 32'h0, 1, 32'h55, 0, 0, 1);

        // Lock stimulus: lock0 on the first three captures by 0, released on the fourth.
        cycle(0, 32'h0, 0, 32'h0, 0, 0, 1);
        cycle(0, 32'h0, 0, 32'h0, 0, 0, 1);
        for (int i = 0; i < 10; i++)
            cycle(1, 32'h100 + i, 1, 32'h200 + i, (i < 3) ? 1'b1 : 1'b0, 0, 1);

        // Random traffic; requesters hold req/data until granted.
        p0 = 0; p1 = 0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0) begin p0 = $urandom_range(0, 1); pd0 = $urandom; end
            if (!p1) begin p1 = $urandom_range(0, 1); pd1 = $urandom; end
            l0 = ($urandom_range(0, 3) == 0);
            l1 = ($urandom_range(0, 3) == 0);
            cycle(p0, pd0, p1, pd1, l0, l1, $urandom_range(0, 3) != 0);
            if (m_last_gnt == 0) p0 = 0;
            if (m_last_gnt == 1) p1 = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
